// File: rtl/seg7_dbg_scan.sv
// Multi-channel 7-segment debug display: selects one of NUM_CH 32-bit words,
// snapshots it, and time-multiplexes its nibbles onto up to 8 hex digits.
module seg7_dbg_scan #(
   parameter int DIGITS     = 8,
   parameter int NUM_CH     = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int ROT_PERIOD = 100000000,
   parameter int BLANK_LZ   = 1
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  cs,
   input  logic [NUM_CH*32-1:0]  i_data,
   input  logic                  i_ch_next,
   input  logic                  i_auto,
   input  logic                  i_freeze,
   output logic [7:0]            o_seg,
   output logic [7:0]            o_sel,
   output logic [2:0]            o_ch
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int RW = (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [RW-1:0] ROT_LAST  = RW'(ROT_PERIOD - 1);
   localparam logic [2:0]    CH_LAST   = 3'(NUM_CH - 1);
   localparam logic [2:0]    DIG_LAST  = 3'(DIGITS - 1);

   logic [2:0]    ch_q, ch_d;
   logic          prev_next_q;
   logic [RW-1:0] rot_cnt_q, rot_cnt_d;
   logic [31:0]   snap_q, snap_d;
   logic [SW-1:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]    dig_q, dig_d;
   logic [7:0]    seg_q, seg_d;
   logic [7:0]    sel_q, sel_d;

   logic [31:0] ch_word [NUM_CH];
   logic [31:0] sel_word;
   logic [31:0] shifted;
   logic        manual_edge, rot_term, advance, blank;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign ch_word[gi] = i_data[32*gi +: 32];
      end
   endgenerate

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      sel_word = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_q == 3'(k)) sel_word = ch_word[k];
      end
   end

   // A manual edge and a rotation terminal in the same cycle merge into one advance.
   assign manual_edge = i_ch_next & ~prev_next_q;
   assign rot_term    = i_auto & (rot_cnt_q == ROT_LAST);
   assign advance     = manual_edge | rot_term;

   assign shifted = snap_q >> {dig_q, 2'b00};
   assign blank   = (BLANK_LZ != 0) && (dig_q != 3'd0) && (shifted == 32'd0);

   always_comb begin
      ch_d       = ch_q;
      rot_cnt_d  = rot_cnt_q + 1'b1;
      snap_d     = snap_q;
      scan_cnt_d = scan_cnt_q + 1'b1;
      dig_d      = dig_q;

      if (advance) ch_d = (ch_q == CH_LAST) ? 3'd0 : ch_q + 3'd1;
      if (!i_auto || manual_edge || rot_term) rot_cnt_d = '0;
      if (cs && !i_freeze) snap_d = sel_word;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         dig_d      = (dig_q == DIG_LAST) ? 3'd0 : dig_q + 3'd1;
      end

      seg_d = blank ? 8'hFF : {(dig_q != ch_q), hex7(shifted[3:0])};
      sel_d = ~(8'b1 << dig_q);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         ch_q        <= '0;
         prev_next_q <= 1'b0;
         rot_cnt_q   <= '0;
         snap_q      <= '0;
         scan_cnt_q  <= '0;
         dig_q       <= '0;
         seg_q       <= 8'hFF;
         sel_q       <= 8'hFF;
      end else begin
         ch_q        <= ch_d;
         prev_next_q <= i_ch_next;
         rot_cnt_q   <= rot_cnt_d;
         snap_q      <= snap_d;
         scan_cnt_q  <= scan_cnt_d;
         dig_q       <= dig_d;
         seg_q       <= seg_d;
         sel_q       <= sel_d;
      end
   end

   assign o_seg = seg_q;
   assign o_sel = sel_q;
   assign o_ch  = ch_q;

endmodule
